// File: rtl/mem_bridge_pkg.sv
// Shared types and helpers for the parametrised load/store memory bridge.
// Funct3 width codes, FSM state encoding and access sizing functions.
package mem_bridge_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    CAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Zero marks a reserved width code.
  function automatic logic [2:0] access_bytes(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      F3_W:        return 3'd4;
      default:     return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] beats(input logic [2:0] f3, input int lanes);
    int n;
    n = int'(access_bytes(f3));
    if (n <= lanes) return 3'd1;
    return 3'(n / lanes);
  endfunction

  function automatic logic reserved_op(input logic store, input logic [2:0] f3);
    return (access_bytes(f3) == 3'd0) || (store && f3[2]);
  endfunction

  function automatic logic [1:0] align_mask(input logic [2:0] f3);
    case (access_bytes(f3))
      3'd2:    return 2'b01;
      3'd4:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: rotates store bytes onto memory lanes for one beat,
// and gathers captured load bytes into a sign- or zero-extended 32-bit result.
module mem_lane_align
  import mem_bridge_pkg::*;
#(
  parameter int MDW = 8
) (
  input  logic [1:0]       off,
  input  logic [2:0]       nbytes,
  input  logic [1:0]       beat,
  input  logic             sgn,
  input  logic [31:0]      wdat,
  input  logic [31:0]      cap,
  output logic [MDW/8-1:0] be,
  output logic [MDW-1:0]   wd,
  output logic [31:0]      rdata
);

  localparam int LANES = MDW / 8;

  always_comb begin
    int bpb;
    int rel;
    int src;
    int s;
    logic [31:0] gath;
    bpb  = 0;
    rel  = 0;
    src  = 0;
    s    = 0;
    gath = '0;
    be   = '0;
    wd   = '0;
    bpb = (int'(nbytes) < LANES) ? int'(nbytes) : LANES;
    // Lane l carries byte (l - off) of the current beat.
    for (int l = 0; l < LANES; l++) begin
      rel = (l + 4 - int'(off)) % LANES;
      src = int'(beat) * bpb + rel;
      if (rel < bpb && src < 4) begin
        be[l]         = 1'b1;
        wd[l*8 +: 8]  = wdat[src*8 +: 8];
      end
    end
    for (int j = 0; j < 4; j++) begin
      s = int'(off) + j;
      if (j < int'(nbytes) && s < 4) gath[j*8 +: 8] = cap[s*8 +: 8];
    end
    case (nbytes)
      3'd1:    rdata = {{24{sgn & gath[7]}}, gath[7:0]};
      3'd2:    rdata = {{16{sgn & gath[15]}}, gath[15:0]};
      default: rdata = gath;
    endcase
  end

endmodule

// File: rtl/mem_bridge.sv
// Splits RV32I loads/stores into MDW-wide memory beats with WAIT extra cycles per beat.
// Define MEM_BRIDGE_MISALIGN_ERR_EN to add an err output that rejects misaligned/reserved ops.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int MABL = 19,
  parameter int MDW  = 8,
  parameter int WAIT = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic                         opcode5,
  input  logic [2:0]                   funct3,
  input  logic [MABL-1:0]              mem_ad,
  input  logic [31:0]                  mem_wd,
  output logic                         ready,
  output logic [31:0]                  mem_rd,
  output logic                         busy,
  input  logic [MDW-1:0]               rd,
  output logic                         we,
  output logic [MDW/8-1:0]             be,
  output logic [MDW-1:0]               wd,
  output logic [MABL-$clog2(MDW/8)-1:0] ad
`ifdef MEM_BRIDGE_MISALIGN_ERR_EN
  ,
  output logic                         err
`endif
);

  localparam int LANES = MDW / 8;
  localparam int LSB   = $clog2(LANES);
  localparam int AW    = MABL - LSB;
  localparam logic [1:0] OFF_MASK = 2'(LANES - 1);

  state_e            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic              store_q, store_d;
  logic [2:0]        f3_q, f3_d;
  logic [MABL-1:0]   addr_q, addr_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [31:0]       cap_q, cap_d;
  logic [31:0]       mem_rd_q, mem_rd_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              we_q, we_d;
  logic [LANES-1:0]  be_q, be_d;
  logic [MDW-1:0]    wd_q, wd_d;
  logic [AW-1:0]     ad_q, ad_d;

  logic [LANES-1:0]  al_be;
  logic [MDW-1:0]    al_wd;
  logic [31:0]       al_rdata;
  logic [1:0]        req_mask;
  logic              bad_req;
  logic              last_beat;

  assign req_mask  = align_mask(funct3);
  assign last_beat = (3'(beat_q) + 3'd1) == beats(f3_q, LANES);

`ifdef MEM_BRIDGE_MISALIGN_ERR_EN
  logic err_q, err_d;
  assign bad_req = reserved_op(opcode5, funct3) || (|(mem_ad[1:0] & req_mask));
  assign err     = err_q;
`else
  assign bad_req = reserved_op(opcode5, funct3);
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wcnt_d  = wcnt_q;
    store_d = store_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    cap_d   = cap_q;
`ifdef MEM_BRIDGE_MISALIGN_ERR_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          store_d = opcode5;
          f3_d    = funct3;
          wdat_d  = mem_wd;
          beat_d  = 2'd0;
          wcnt_d  = 3'd0;
          cap_d   = '0;
`ifdef MEM_BRIDGE_MISALIGN_ERR_EN
          addr_d  = mem_ad;
          err_d   = bad_req;
`else
          addr_d  = {mem_ad[MABL-1:2], mem_ad[1:0] & ~req_mask};
`endif
          state_d = bad_req ? DONE : ACC;
        end
      end
      ACC: begin
        if (wcnt_q == 3'(WAIT)) begin
          wcnt_d = 3'd0;
          if (!store_q) begin
            state_d = CAP;
          end else if (last_beat) begin
            state_d = DONE;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      CAP: begin
        // Memory data of this beat lands in capture bytes beat*LANES upward.
        for (int l = 0; l < LANES; l++) begin
          if (int'(beat_q) * LANES + l < 4)
            cap_d[(int'(beat_q) * LANES + l) * 8 +: 8] = rd[l*8 +: 8];
        end
        if (last_beat) begin
          state_d = DONE;
        end else begin
          beat_d  = beat_q + 2'd1;
          state_d = ACC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  mem_lane_align #(.MDW(MDW)) u_align (
    .off   (addr_d[1:0] & OFF_MASK),
    .nbytes(access_bytes(f3_d)),
    .beat  (beat_d),
    .sgn   (~f3_d[2]),
    .wdat  (wdat_d),
    .cap   (cap_d),
    .be    (al_be),
    .wd    (al_wd),
    .rdata (al_rdata)
  );

  // Outputs are registered from the next-state view so they line up with the state.
  always_comb begin
    ready_d  = (state_d == DONE);
    busy_d   = (state_d != IDLE);
    we_d     = (state_d == ACC) && store_d;
    be_d     = (state_d == ACC) ? al_be : '0;
    wd_d     = we_d ? al_wd : '0;
    ad_d     = (state_d == ACC) ? addr_d[MABL-1:LSB] + AW'(beat_d) : '0;
    mem_rd_d = mem_rd_q;
    if (state_d == DONE) mem_rd_d = (state_q == IDLE || store_q) ? 32'd0 : al_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= 2'd0;
      wcnt_q   <= 3'd0;
      store_q  <= 1'b0;
      f3_q     <= 3'd0;
      addr_q   <= '0;
      wdat_q   <= '0;
      cap_q    <= '0;
      mem_rd_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wd_q     <= '0;
      ad_q     <= '0;
`ifdef MEM_BRIDGE_MISALIGN_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      wcnt_q   <= wcnt_d;
      store_q  <= store_d;
      f3_q     <= f3_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      cap_q    <= cap_d;
      mem_rd_q <= mem_rd_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wd_q     <= wd_d;
      ad_q     <= ad_d;
`ifdef MEM_BRIDGE_MISALIGN_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  assign ready  = ready_q;
  assign mem_rd = mem_rd_q;
  assign busy   = busy_q;
  assign we     = we_q;
  assign be     = be_q;
  assign wd     = wd_q;
  assign ad     = ad_q;

endmodule
